// File: rtl/tl_ul_uart.sv
// tl_ul_uart: TileLink-UL slave exposing an 8N1 UART (TX shifter, RX sampler, RX FIFO).
// Registers (address[3:2]): 0 TXDATA, 1 RXDATA, 2 STATUS, 3 CTRL.
// Optional feature macro: UART_IRQ_EN enables CTRL interrupt enables and the irq output.
module tl_ul_uart #(
  parameter int XLEN        = 32,
  parameter int SID_WIDTH   = 8,
  parameter int CLK_FREQ_HZ = 27000000,
  parameter int BAUD_RATE   = 115200,
  parameter int RX_DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tl_a_valid,
  output logic                 tl_a_ready,
  input  logic [2:0]           tl_a_opcode,
  input  logic [2:0]           tl_a_param,
  input  logic [2:0]           tl_a_size,
  input  logic [SID_WIDTH-1:0] tl_a_source,
  input  logic [XLEN-1:0]      tl_a_address,
  input  logic [XLEN/8-1:0]    tl_a_mask,
  input  logic [XLEN-1:0]      tl_a_data,
  output logic                 tl_d_valid,
  input  logic                 tl_d_ready,
  output logic [2:0]           tl_d_opcode,
  output logic [1:0]           tl_d_param,
  output logic [2:0]           tl_d_size,
  output logic [SID_WIDTH-1:0] tl_d_source,
  output logic [XLEN-1:0]      tl_d_data,
  output logic                 tl_d_corrupt,
  output logic                 tl_d_denied,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  output logic                 irq
);
  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

  // cross-block control strobes
  logic       tx_load, tx_busy, rx_pop, rx_push, rx_ferr, clr_ovr, clr_ferr, ctrl_we;
  logic       rx_nonempty, rx_full, fifo_wr;
  logic [1:0] ctrl_rd;

  // ---------------- TX ----------------
  uart_state_t   tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;

  assign tx_busy = (tx_state_q != ST_IDLE);
  // Line level decoded from state so an async reset returns the wire high at once.
  assign uart_tx = (tx_state_q == ST_START) ? 1'b0 :
                   (tx_state_q == ST_DATA)  ? tx_shift_q[0] : 1'b1;

  // TX next state: each phase lasts DIV cycles, data shifted out LSB first
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    if (tx_state_q == ST_IDLE) begin
      if (tx_load) begin
        tx_state_d = ST_START;
        tx_cnt_d   = '0;
        tx_shift_d = tl_a_data[7:0];
      end
    end else if (tx_cnt_q == CW'(DIV - 1)) begin
      tx_cnt_d = '0;
      if (tx_state_q == ST_START) begin
        tx_state_d = ST_DATA;
        tx_bit_d   = '0;
      end else if (tx_state_q == ST_DATA) begin
        tx_shift_d = {1'b0, tx_shift_q[7:1]};
        tx_bit_d   = tx_bit_q + 3'd1;
        if (tx_bit_q == 3'd7) tx_state_d = ST_STOP;
      end else begin
        tx_state_d = ST_IDLE;
      end
    end else begin
      tx_cnt_d = tx_cnt_q + CW'(1);
    end
  end

  // ---------------- RX ----------------
  uart_state_t   rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_sync1_q, rx_sync2_q, rx_prev_q;

  // RX next state: start edge, mid-start check, then mid-bit samples every DIV cycles
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        rx_cnt_d = '0;
        if (rx_prev_q && !rx_sync2_q) rx_state_d = ST_START;
      end
      ST_START: begin
        if (rx_cnt_q == CW'(DIV / 2 - 1)) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync2_q ? ST_IDLE : ST_DATA;  // high at mid-start: glitch
        end
      end
      ST_DATA: begin
        if (rx_cnt_q == CW'(DIV - 1)) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
        end
      end
      default: begin
        if (rx_cnt_q == CW'(DIV - 1)) begin
          rx_cnt_d   = '0;
          rx_state_d = ST_IDLE;
          rx_push    = rx_sync2_q;
          rx_ferr    = !rx_sync2_q;
        end
      end
    endcase
  end

  // ---------------- RX FIFO and sticky status ----------------
  logic [7:0]    fifo_mem [RX_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overrun_q, overrun_d, ferr_q, ferr_d;

  assign rx_nonempty = (count_q != '0);
  assign rx_full     = (count_q == (AW + 1)'(RX_DEPTH));
  assign fifo_wr     = rx_push && !rx_full;

  // FIFO pointers/count; a full FIFO drops the new byte and flags overrun
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q && !clr_ovr;
    ferr_d    = ferr_q && !clr_ferr;
    if (fifo_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rx_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (fifo_wr && !rx_pop)      count_d = count_q + (AW + 1)'(1);
    else if (!fifo_wr && rx_pop) count_d = count_q - (AW + 1)'(1);
    if (rx_push && rx_full) overrun_d = 1'b1;
    if (rx_ferr)            ferr_d    = 1'b1;
  end

  // FIFO storage write port (contents need no reset)
  always_ff @(posedge clk) begin
    if (fifo_wr) fifo_mem[wr_ptr_q] <= rx_shift_q;
  end

  // ---------------- TileLink response ----------------
  logic                 d_valid_q, d_valid_d, d_denied_q, d_denied_d;
  logic [2:0]           d_opcode_q, d_opcode_d, d_size_q, d_size_d;
  logic [SID_WIDTH-1:0] d_source_q, d_source_d;
  logic [XLEN-1:0]      d_data_q, d_data_d;
  logic                 a_fire;

  assign a_fire = tl_a_valid && tl_a_ready;

  // Decode accepted request, generate side-effect strobes and the registered response
  always_comb begin
    d_valid_d  = d_valid_q;
    d_denied_d = d_denied_q;
    d_opcode_d = d_opcode_q;
    d_size_d   = d_size_q;
    d_source_d = d_source_q;
    d_data_d   = d_data_q;
    tx_load    = 1'b0;
    rx_pop     = 1'b0;
    clr_ovr    = 1'b0;
    clr_ferr   = 1'b0;
    ctrl_we    = 1'b0;
    if (d_valid_q && tl_d_ready) d_valid_d = 1'b0;
    if (a_fire) begin
      d_valid_d  = 1'b1;
      d_size_d   = tl_a_size;
      d_source_d = tl_a_source;
      d_data_d   = '0;
      d_denied_d = 1'b0;
      d_opcode_d = 3'd0;
      case (tl_a_opcode)
        3'd4: begin
          d_opcode_d = 3'd1;
          case (tl_a_address[3:2])
            2'd0: d_data_d[0] = tx_busy;
            2'd1: begin
              if (rx_nonempty) begin
                d_data_d[7:0] = fifo_mem[rd_ptr_q];
                rx_pop        = 1'b1;
              end else begin
                d_data_d[31] = 1'b1;
              end
            end
            2'd2: d_data_d[4:0] = {ferr_q, overrun_q, rx_full, rx_nonempty, tx_busy};
            default: d_data_d[1:0] = ctrl_rd;
          endcase
        end
        3'd0, 3'd1: begin
          if (tl_a_mask[0]) begin
            case (tl_a_address[3:2])
              2'd0: begin
                if (tx_busy) d_denied_d = 1'b1;
                else         tx_load    = 1'b1;
              end
              2'd2: begin
                clr_ovr  = tl_a_data[3];
                clr_ferr = tl_a_data[4];
              end
              2'd3:    ctrl_we = 1'b1;
              default: ;
            endcase
          end
        end
        default: d_denied_d = 1'b1;
      endcase
    end
  end

  // All state registers; async reset aborts any frame in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state_q <= ST_IDLE;  tx_cnt_q <= '0;  tx_bit_q <= '0;  tx_shift_q <= '0;
      rx_state_q <= ST_IDLE;  rx_cnt_q <= '0;  rx_bit_q <= '0;  rx_shift_q <= '0;
      rx_sync1_q <= 1'b1;     rx_sync2_q <= 1'b1;  rx_prev_q <= 1'b1;
      wr_ptr_q   <= '0;       rd_ptr_q <= '0;  count_q <= '0;
      overrun_q  <= 1'b0;     ferr_q <= 1'b0;
      d_valid_q  <= 1'b0;     d_denied_q <= 1'b0;  d_opcode_q <= '0;
      d_size_q   <= '0;       d_source_q <= '0;    d_data_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;  tx_cnt_q <= tx_cnt_d;  tx_bit_q <= tx_bit_d;  tx_shift_q <= tx_shift_d;
      rx_state_q <= rx_state_d;  rx_cnt_q <= rx_cnt_d;  rx_bit_q <= rx_bit_d;  rx_shift_q <= rx_shift_d;
      rx_sync1_q <= uart_rx;     rx_sync2_q <= rx_sync1_q;  rx_prev_q <= rx_sync2_q;
      wr_ptr_q   <= wr_ptr_d;    rd_ptr_q <= rd_ptr_d;  count_q <= count_d;
      overrun_q  <= overrun_d;   ferr_q <= ferr_d;
      d_valid_q  <= d_valid_d;   d_denied_q <= d_denied_d;  d_opcode_q <= d_opcode_d;
      d_size_q   <= d_size_d;    d_source_q <= d_source_d;  d_data_q <= d_data_d;
    end
  end

  assign tl_a_ready   = !d_valid_q;
  assign tl_d_valid   = d_valid_q;
  assign tl_d_opcode  = d_opcode_q;
  assign tl_d_param   = 2'b00;
  assign tl_d_size    = d_size_q;
  assign tl_d_source  = d_source_q;
  assign tl_d_data    = d_data_q;
  assign tl_d_corrupt = 1'b0;
  assign tl_d_denied  = d_denied_q;

`ifdef UART_IRQ_EN
  logic rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d, irq_q, irq_d;

  // Interrupt enables and registered level interrupt
  always_comb begin
    rx_ie_d = rx_ie_q;
    tx_ie_d = tx_ie_q;
    if (ctrl_we) begin
      rx_ie_d = tl_a_data[0];
      tx_ie_d = tl_a_data[1];
    end
    irq_d = (rx_ie_q && rx_nonempty) || (tx_ie_q && !tx_busy);
  end

  // Interrupt state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_ie_q <= 1'b0;
      tx_ie_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      rx_ie_q <= rx_ie_d;
      tx_ie_q <= tx_ie_d;
      irq_q   <= irq_d;
    end
  end

  assign ctrl_rd = {tx_ie_q, rx_ie_q};
  assign irq     = irq_q;
`else
  logic unused_ctrl;
  assign ctrl_rd     = 2'b00;
  assign irq         = 1'b0;
  assign unused_ctrl = ctrl_we;
`endif

  // Request fields this slave never looks at
  logic unused_bits;
  assign unused_bits = ^{tl_a_param, tl_a_address[XLEN-1:4], tl_a_address[1:0],
                         tl_a_mask[XLEN/8-1:1], tl_a_data[XLEN-1:8]};
endmodule

// File: tb/tb_tl_ul_uart.sv
// tb_tl_ul_uart: scoreboard bench for tl_ul_uart at DIV=8, RX_DEPTH=4.
module tb_tl_ul_uart;
  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [1:0] R_TX = 2'd0, R_RX = 2'd1, R_STATUS = 2'd2, R_CTRL = 2'd3;
`ifdef UART_IRQ_EN
  localparam logic [31:0] CTRL_EXP = 32'h1;
  localparam logic        IRQ_EXP  = 1'b1;
`else
  localparam logic [31:0] CTRL_EXP = 32'h0;
  localparam logic        IRQ_EXP  = 1'b0;
`endif

  logic        clk, rst;
  logic        tl_a_valid, tl_a_ready;
  logic [2:0]  tl_a_opcode, tl_a_param, tl_a_size;
  logic [7:0]  tl_a_source;
  logic [31:0] tl_a_address, tl_a_data;
  logic [3:0]  tl_a_mask;
  logic        tl_d_valid, tl_d_ready;
  logic [2:0]  tl_d_opcode, tl_d_size;
  logic [1:0]  tl_d_param;
  logic [7:0]  tl_d_source;
  logic [31:0] tl_d_data;
  logic        tl_d_corrupt, tl_d_denied;
  logic        uart_rx, uart_tx, irq;

  tl_ul_uart #(.XLEN(32), .SID_WIDTH(8), .CLK_FREQ_HZ(8), .BAUD_RATE(1), .RX_DEPTH(4)) dut (
    .clk(clk), .reset(rst),
    .tl_a_valid(tl_a_valid), .tl_a_ready(tl_a_ready), .tl_a_opcode(tl_a_opcode),
    .tl_a_param(tl_a_param), .tl_a_size(tl_a_size), .tl_a_source(tl_a_source),
    .tl_a_address(tl_a_address), .tl_a_mask(tl_a_mask), .tl_a_data(tl_a_data),
    .tl_d_valid(tl_d_valid), .tl_d_ready(tl_d_ready), .tl_d_opcode(tl_d_opcode),
    .tl_d_param(tl_d_param), .tl_d_size(tl_d_size), .tl_d_source(tl_d_source),
    .tl_d_data(tl_d_data), .tl_d_corrupt(tl_d_corrupt), .tl_d_denied(tl_d_denied),
    .uart_rx(uart_rx), .uart_tx(uart_tx), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  opcode;
    logic [31:0] data;
    logic        denied;
    logic [7:0]  source;
    logic [2:0]  size;
  } exp_t;

  exp_t       sb[$];        // expected D responses
  logic [7:0] tx_exp[$];    // expected bytes on uart_tx
  logic [7:0] rx_model[$];  // reference RX FIFO
  logic       exp_ovr, exp_ferr, rst_done, mon_en;
  int         n_checks, n_errors;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // One TL-UL transaction; expected response queued at issue, popped on D-valid.
  task automatic tl_req(input logic [2:0] op, input logic [1:0] ridx, input logic [31:0] wdata,
                        input logic [3:0] mask, input logic [7:0] src, input logic [31:0] exp_data,
                        input logic exp_denied, input int hold, input string tag);
    exp_t e;
    exp_t g;
    int   n;
    e.opcode = (op == OP_GET) ? 3'd1 : 3'd0;
    e.data   = exp_data;
    e.denied = exp_denied;
    e.source = src;
    e.size   = 3'd2;
    sb.push_back(e);
    tl_a_valid   = 1'b1;
    tl_a_opcode  = op;
    tl_a_param   = 3'd0;
    tl_a_size    = 3'd2;
    tl_a_source  = src;
    tl_a_address = 32'hABC0_0000 | {28'h0, ridx, 2'b00};
    tl_a_mask    = mask;
    tl_a_data    = wdata;
    tl_d_ready   = (hold == 0);
    n = 0;
    while (!tl_a_ready && n < 20) begin @(negedge clk); n++; end
    check({tag, "_a_ready"}, tl_a_ready, 1);
    @(negedge clk);
    tl_a_valid = 1'b0;
    check({tag, "_d_latency"}, tl_d_valid, 1);
    n = 0;
    while (!tl_d_valid && n < 20) begin @(negedge clk); n++; end
    g = sb.pop_front();
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_valid"}, tl_d_valid, 1);
      check({tag, "_hold_a_ready"}, tl_a_ready, 0);
      check({tag, "_hold_source"}, tl_d_source, g.source);
      check({tag, "_hold_data"}, tl_d_data, g.data);
      @(negedge clk);
    end
    tl_d_ready = 1'b1;
    check({tag, "_opcode"}, tl_d_opcode, g.opcode);
    check({tag, "_denied"}, tl_d_denied, g.denied);
    check({tag, "_source"}, tl_d_source, g.source);
    check({tag, "_size"}, tl_d_size, g.size);
    check({tag, "_param_corrupt"}, {tl_d_param, tl_d_corrupt}, 0);
    if (g.opcode == 3'd1) check({tag, "_data"}, tl_d_data, g.data);
    @(negedge clk);
    check({tag, "_d_done"}, tl_d_valid, 0);
  endtask

  task automatic read_status(input logic busy, input string tag);
    logic [31:0] exp;
    exp = {27'd0, exp_ferr, exp_ovr, rx_model.size() == 4, rx_model.size() != 0, busy};
    tl_req(OP_GET, R_STATUS, 32'h0, 4'hF, 8'h10, exp, 1'b0, 0, tag);
  endtask

  task automatic read_rx(input string tag);
    logic [31:0] exp;
    if (rx_model.size() != 0) exp = {24'd0, rx_model.pop_front()};
    else                      exp = 32'h8000_0000;
    tl_req(OP_GET, R_RX, 32'h0, 4'hF, 8'h11, exp, 1'b0, 0, tag);
  endtask

  // Serial frame into uart_rx; reference model updated with the expected outcome.
  task automatic send_rx(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (8) @(negedge clk);
    end
    uart_rx = stop;
    repeat (8) @(negedge clk);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    if (!stop)                     exp_ferr = 1'b1;
    else if (rx_model.size() < 4)  rx_model.push_back(b);
    else                           exp_ovr = 1'b1;
  endtask

  // TX monitor: every frame compared cycle by cycle against the next expected byte
  initial begin
    logic [79:0] obs, expw;
    logic [7:0]  b;
    wait (rst_done);
    forever begin
      @(negedge uart_tx);
      if (mon_en) begin
        check("tx_frame_expected", tx_exp.size() != 0, 1);
        b = (tx_exp.size() != 0) ? tx_exp.pop_front() : 8'h00;
        for (int k = 0; k < 80; k++) begin
          @(negedge clk);
          obs[k]  = uart_tx;
          expw[k] = (k < 8) ? 1'b0 : (k < 72) ? b[(k - 8) / 8] : 1'b1;
        end
        check("tx_wave", obs, expw);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_errors = 0; exp_ovr = 1'b0; exp_ferr = 1'b0;
    rst_done = 1'b0; mon_en = 1'b1;
    tl_a_valid = 1'b0; tl_a_opcode = 3'd0; tl_a_param = 3'd0; tl_a_size = 3'd0;
    tl_a_source = 8'd0; tl_a_address = 32'd0; tl_a_mask = 4'd0; tl_a_data = 32'd0;
    tl_d_ready = 1'b1; uart_rx = 1'b1; rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_a_ready", tl_a_ready, 1);
    check("reset_d_valid", tl_d_valid, 0);
    check("reset_d_fields", {tl_d_opcode, tl_d_param, tl_d_size, tl_d_source, tl_d_data,
                             tl_d_corrupt, tl_d_denied}, 0);
    check("reset_uart_tx", uart_tx, 1);
    check("reset_irq", irq, 0);
    rst = 1'b0;
    rst_done = 1'b1;
    @(negedge clk);

    // TX 0x55, busy reads, rejected second write
    tx_exp.push_back(8'h55);
    tl_req(OP_PUT_FULL, R_TX, 32'h55, 4'hF, 8'h01, 32'h0, 1'b0, 0, "tx_write_55");
    read_status(1'b1, "status_tx_busy");
    tl_req(OP_PUT_FULL, R_TX, 32'hAA, 4'hF, 8'h02, 32'h0, 1'b1, 0, "tx_write_busy_aa");
    tl_req(OP_GET, R_TX, 32'h0, 4'hF, 8'h03, 32'h1, 1'b0, 0, "txdata_read_busy");
    repeat (6) begin
      read_status(1'b1, "status_in_frame");
      repeat (4) @(negedge clk);
    end
    repeat (40) @(negedge clk);
    read_status(1'b0, "status_tx_done");

    // Back-pressure on D and illegal opcode
    tl_req(OP_GET, R_STATUS, 32'h0, 4'hF, 8'h2A, 32'h0, 1'b0, 5, "hold_get");
    tl_req(3'd3, R_TX, 32'h12, 4'hF, 8'h04, 32'h0, 1'b1, 0, "bad_opcode");
    repeat (12) @(negedge clk);
    read_status(1'b0, "status_after_bad_op");

    // Single RX byte
    send_rx(8'hA3, 1'b1);
    read_status(1'b0, "status_rx_nonempty");
    read_rx("rxdata_a3");
    read_rx("rxdata_empty");

    // Overrun with five frames
    for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1);
    read_status(1'b0, "status_overrun");
    for (int i = 0; i < 5; i++) read_rx("rxdata_drain");
    tl_req(OP_PUT_FULL, R_STATUS, 32'h8, 4'hF, 8'h05, 32'h0, 1'b0, 0, "clear_overrun");
    exp_ovr = 1'b0;
    read_status(1'b0, "status_overrun_cleared");

    // Framing error, then a short glitch
    send_rx(8'h3C, 1'b0);
    read_status(1'b0, "status_frame_err");
    read_rx("rxdata_after_ferr");
    tl_req(OP_PUT_FULL, R_STATUS, 32'h10, 4'hF, 8'h06, 32'h0, 1'b0, 0, "clear_ferr");
    exp_ferr = 1'b0;
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (100) @(negedge clk);
    read_status(1'b0, "status_after_glitch");
    read_rx("rxdata_after_glitch");

    // CTRL and interrupt
    tl_req(OP_PUT_PART, R_CTRL, 32'h1, 4'h1, 8'h07, 32'h0, 1'b0, 0, "ctrl_write");
    tl_req(OP_GET, R_CTRL, 32'h0, 4'hF, 8'h08, CTRL_EXP, 1'b0, 0, "ctrl_read");
    send_rx(8'h5A, 1'b1);
    check("irq_rx_pending", irq, IRQ_EXP);
    read_rx("rxdata_5a");
    repeat (2) @(negedge clk);
    check("irq_drained", irq, 0);
    tl_req(OP_PUT_FULL, R_CTRL, 32'h0, 4'hF, 8'h09, 32'h0, 1'b0, 0, "ctrl_clear");

    // Reset in the middle of a TX frame and an RX frame
    mon_en = 1'b0;
    tl_req(OP_PUT_FULL, R_TX, 32'h3C, 4'hF, 8'h0A, 32'h0, 1'b0, 0, "tx_write_abort");
    uart_rx = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midframe_reset_uart_tx", uart_tx, 1);
    @(negedge clk);
    uart_rx = 1'b1;
    rst = 1'b0;
    repeat (100) @(negedge clk);
    mon_en = 1'b1;
    read_status(1'b0, "status_after_abort");
    read_rx("rxdata_after_abort");

    check("tx_pending", tx_exp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
